// File: rtl/prf_free_list.sv
// Circular free list of physical register ids for a 2-wide rename stage.
// Speculative head for allocation, committed head for one-cycle flush recovery.
module prf_free_list #(
  parameter int unsigned FL_NUM    = 32,
  parameter int unsigned FL_WIDTH  = 5,
  parameter int unsigned PRF_WIDTH = 6,
  parameter int unsigned ARF_NUM   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [1:0]           i_alloc_req,
  output logic                 o_alloc_ready,
  output logic [PRF_WIDTH-1:0] o_alloc_prf0,
  output logic [PRF_WIDTH-1:0] o_alloc_prf1,
  input  logic [1:0]           i_retire_wb,
  input  logic [PRF_WIDTH-1:0] i_retire_told0,
  input  logic [PRF_WIDTH-1:0] i_retire_told1,
  input  logic                 i_flush,
  output logic [FL_WIDTH:0]    o_free_count,
  output logic                 o_empty
);

  localparam int unsigned PtrW = FL_WIDTH + 1;

  logic [PRF_WIDTH-1:0] r_mem [FL_NUM];
  logic [PtrW-1:0]      r_head;
  logic [PtrW-1:0]      r_commit_head;
  logic [PtrW-1:0]      r_tail;

  logic [PtrW-1:0]      w_head_p1;
  logic [PtrW-1:0]      w_tail_p1;
  logic [1:0]           w_alloc_cnt;
  logic [1:0]           w_rel_cnt;
  logic                 w_fire;
  logic [PRF_WIDTH-1:0] w_wr_data0;

  always_comb begin
    w_head_p1     = r_head + PtrW'(1);
    w_tail_p1     = r_tail + PtrW'(1);
    w_alloc_cnt   = {1'b0, i_alloc_req[0]} + {1'b0, i_alloc_req[1]};
    w_rel_cnt     = {1'b0, i_retire_wb[0]} + {1'b0, i_retire_wb[1]};
    o_free_count  = r_tail - r_head;
    o_alloc_ready = o_free_count >= PtrW'(2);
    o_empty       = o_free_count == '0;
    w_fire        = o_alloc_ready & (|i_alloc_req) & ~i_flush;
    o_alloc_prf0  = r_mem[r_head[FL_WIDTH-1:0]];
    o_alloc_prf1  = i_alloc_req[0] ? r_mem[w_head_p1[FL_WIDTH-1:0]]
                                   : r_mem[r_head[FL_WIDTH-1:0]];
    // Releases pack into consecutive slots; a lone slot-1 release lands at tail.
    w_wr_data0    = i_retire_wb[0] ? i_retire_told0 : i_retire_told1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < int'(FL_NUM); i++) begin
        r_mem[i] <= PRF_WIDTH'(ARF_NUM + i);
      end
    end else begin
      if (|i_retire_wb) begin
        r_mem[r_tail[FL_WIDTH-1:0]] <= w_wr_data0;
      end
      if (&i_retire_wb) begin
        r_mem[w_tail_p1[FL_WIDTH-1:0]] <= i_retire_told1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_head        <= '0;
      r_commit_head <= '0;
      r_tail        <= PtrW'(FL_NUM);
    end else begin
      r_tail        <= r_tail + PtrW'(w_rel_cnt);
      r_commit_head <= r_commit_head + PtrW'(w_rel_cnt);
      // Flush rewinds to the committed point including this cycle's retirements.
      if (i_flush) begin
        r_head <= r_commit_head + PtrW'(w_rel_cnt);
      end else if (w_fire) begin
        r_head <= r_head + PtrW'(w_alloc_cnt);
      end
    end
  end

  a_release_overflow : assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (w_rel_cnt != 2'd0) |-> (int'(o_free_count) + int'(w_rel_cnt) <= int'(FL_NUM)));

  a_fire_not_ready : assert property (@(posedge i_clk) disable iff (!i_reset_n)
    w_fire |-> o_alloc_ready);

  a_told0_zero : assert property (@(posedge i_clk) disable iff (!i_reset_n)
    i_retire_wb[0] |-> (i_retire_told0 != '0));

  a_told1_zero : assert property (@(posedge i_clk) disable iff (!i_reset_n)
    i_retire_wb[1] |-> (i_retire_told1 != '0));

endmodule

// File: tb/tb_prf_free_list.sv
// Randomised and directed bench for prf_free_list, scored against a queue model
// holding every id from the committed head to the tail in list order.
module tb_prf_free_list;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] alloc_req;
  logic       alloc_ready;
  logic [5:0] alloc_prf0;
  logic [5:0] alloc_prf1;
  logic [1:0] retire_wb;
  logic [5:0] retire_told0;
  logic [5:0] retire_told1;
  logic       flush;
  logic [5:0] free_count;
  logic       empty;

  always #5 clk = ~clk;

  prf_free_list dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_alloc_req    (alloc_req),
    .o_alloc_ready  (alloc_ready),
    .o_alloc_prf0   (alloc_prf0),
    .o_alloc_prf1   (alloc_prf1),
    .i_retire_wb    (retire_wb),
    .i_retire_told0 (retire_told0),
    .i_retire_told1 (retire_told1),
    .i_flush        (flush),
    .o_free_count   (free_count),
    .o_empty        (empty)
  );

  typedef struct {
    int ready;
    int count;
    int empty;
    int prf0;
    int prf1;
  } exp_t;

  exp_t exp_q[$];
  int   fl[$];   // ids from committed head to tail, oldest first
  int   spec;    // ids handed out since the committed head
  int   total = 0;
  int   bad   = 0;

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    fl.delete();
    for (int i = 0; i < 32; i++) fl.push_back(32 + i);
    spec = 0;
    exp_q.delete();
  endfunction

  task automatic drive(input logic [1:0] req, input logic [1:0] wb, input int t0,
                       input int t1, input logic f);
    exp_t e;
    alloc_req    = req;
    retire_wb    = wb;
    retire_told0 = 6'(t0);
    retire_told1 = 6'(t1);
    flush        = f;
    e.ready = (32 - spec) >= 2;
    e.count = 32 - spec;
    e.empty = (spec == 32);
    e.prf0  = e.ready ? fl[spec] : 0;
    e.prf1  = e.ready ? (req[0] ? fl[spec + 1] : fl[spec]) : 0;
    exp_q.push_back(e);
    if (e.ready != 0 && req != 2'b00 && !f) spec += int'(req[0]) + int'(req[1]);
    if (wb[0]) begin fl.delete(0); fl.push_back(t0); end
    if (wb[1]) begin fl.delete(0); fl.push_back(t1); end
    spec -= int'(wb[0]) + int'(wb[1]);
    if (f) spec = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    alloc_req = 2'b00; retire_wb = 2'b00; flush = 1'b0;
    retire_told0 = 6'd1; retire_told1 = 6'd1;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("ready", int'(alloc_ready), e.ready);
        check("free_count", int'(free_count), e.count);
        check("empty", int'(empty), e.empty);
        if (e.ready != 0) begin
          check("prf0", int'(alloc_prf0), e.prf0);
          check("prf1", int'(alloc_prf1), e.prf1);
        end
      end else if (alloc_ready && alloc_req != 2'b00 && !flush) begin
        total++;
        bad++;
        $display("FAIL unexpected_alloc: got req=%0d with no expectation", alloc_req);
      end
    end
  end

  initial begin
    int nr;
    logic [1:0] req, wb;
    logic f;

    do_reset();

    // Reset values
    drive(2'b00, 2'b00, 1, 1, 1'b0); #2;
    check("rst_count", int'(free_count), 32);
    check("rst_ready", int'(alloc_ready), 1);
    check("rst_empty", int'(empty), 0);
    check("rst_prf0", int'(alloc_prf0), 32);
    tick();

    // Drain the list in pairs
    for (int k = 0; k < 16; k++) begin
      drive(2'b11, 2'b00, 1, 1, 1'b0); #2;
      check("burst_prf0", int'(alloc_prf0), 32 + 2 * k);
      check("burst_prf1", int'(alloc_prf1), 33 + 2 * k);
      tick();
    end
    drive(2'b00, 2'b00, 1, 1, 1'b0); #2;
    check("drained_count", int'(free_count), 0);
    check("drained_empty", int'(empty), 1);
    check("drained_ready", int'(alloc_ready), 0);
    tick();

    // Lone slot-1 release, then a pair
    drive(2'b00, 2'b10, 1, 40, 1'b0); tick();
    drive(2'b00, 2'b11, 41, 42, 1'b0); tick();
    drive(2'b00, 2'b00, 1, 1, 1'b0); #2;
    check("refill_count", int'(free_count), 3);
    check("refill_prf0", int'(alloc_prf0), 40);
    tick();
    drive(2'b11, 2'b00, 1, 1, 1'b0); #2;
    check("refill_prf0b", int'(alloc_prf0), 40);
    check("refill_prf1b", int'(alloc_prf1), 41);
    tick();

    // One id left: single request must still stall
    drive(2'b01, 2'b00, 1, 1, 1'b0); #2;
    check("one_left_ready", int'(alloc_ready), 0);
    tick();
    drive(2'b00, 2'b00, 1, 1, 1'b0); #2;
    check("one_left_count", int'(free_count), 1);
    check("one_left_prf0", int'(alloc_prf0), 42);
    tick();

    // Flush with a same-cycle retirement; alloc in flush cycle is ignored
    do_reset();
    drive(2'b11, 2'b00, 1, 1, 1'b0); tick();
    drive(2'b11, 2'b00, 1, 1, 1'b0); tick();
    drive(2'b11, 2'b01, 7, 1, 1'b1); tick();
    drive(2'b11, 2'b00, 1, 1, 1'b0); #2;
    check("flush_count", int'(free_count), 32);
    check("flush_prf0", int'(alloc_prf0), 33);
    check("flush_prf1", int'(alloc_prf1), 34);
    tick();

    // Asynchronous reset mid-burst
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(2'b01, 2'b00, 1, 1, 1'b0); tick();
    end
    alloc_req = 2'b00; retire_wb = 2'b00; flush = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    check("async_count", int'(free_count), 32);
    check("async_ready", int'(alloc_ready), 1);
    check("async_empty", int'(empty), 0);
    check("async_prf0", int'(alloc_prf0), 32);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      req = 2'($urandom_range(0, 3));
      nr  = int'($urandom_range(0, 2));
      if (nr > spec) nr = spec;
      if (nr == 2) wb = 2'b11;
      else if (nr == 1) wb = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      else wb = 2'b00;
      f = ($urandom_range(0, 19) == 0);
      drive(req, wb, int'($urandom_range(1, 63)), int'($urandom_range(1, 63)), f);
      tick();
    end

    alloc_req = 2'b00; retire_wb = 2'b00; flush = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
